// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the bit-serial adder controller
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

  // Bit counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/result bundle between requester and serial adder
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);

endinterface

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - combinational 1-bit full adder used as the serial datapath
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - sequences one full adder over WIDTH cycles to form a+b+cin
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int                CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_add_ctrl: WIDTH out of range");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  logic             last;

  fa_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
          accept     = 1'b1;
        end
      end
      RUN: begin
        if (cnt == CNT_LAST) begin
          state_next = DONE;
          last       = 1'b1;
        end
      end
      DONE: begin
        accept     = bus.start;
        state_next = bus.start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_sr  <= bus.a;
        b_sr  <= bus.b;
        carry <= bus.cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        carry  <= fa_cout;
        res_sr <= {fa_sum, res_sr[WIDTH-1:1]};
        // Hold the counter on the final bit so it never wraps for power-of-two widths
        if (last) begin
          sum_q  <= {fa_sum, res_sr[WIDTH-1:1]};
          cout_q <= fa_cout;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
